reg_file: RTL



---
 rtl/cpu_pkg.sv | 13 +
 rtl/dff_reg.sv | 30 +++
 rtl/reg_file.sv | 81 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file sizing shared by the datapath stages.
//   REG_WIDTH  - data bits per architectural register
//   REG_DEPTH  - number of architectural registers (power of two)
//   REG_ADDR_W - register address width
//   reg_data_t / reg_addr_t - register data and address types
package cpu_pkg;
  localparam int REG_WIDTH  = 8;
  localparam int REG_DEPTH  = 8;
  localparam int REG_ADDR_W = $clog2(REG_DEPTH);

  typedef logic [REG_WIDTH-1:0]  reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage : cpu_pkg

// File: rtl/dff_reg.sv
// dff_reg: WIDTH-bit edge-triggered register with async active-low clear
// and a load enable.
//   CLK   - clock, loads on rising edge when En=1
//   RST_N - asynchronous active-low clear
//   En    - load enable
//   D     - data in
//   Q     - registered data out
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= '0;
    end else if (En) begin
      q_q <= D;
    end
  end

  assign Q = q_q;

endmodule : dff_reg

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, one synchronous write port and two
// registered read ports with write-first bypass and optional zero register.
//   CLK    - clock, all state updates on rising edge
//   RST_N  - asynchronous active-low reset, clears array and read outputs
//   WE     - write enable
//   WAddr  - write address
//   WData  - write data
//   RAddrA - read port A address
//   RAddrB - read port B address
//   RDataA - registered read data, port A (1-edge latency)
//   RDataB - registered read data, port B (1-edge latency)
// ADDR_W is derived from DEPTH and is not meant to be overridden.
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = REG_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [WIDTH-1:0]  WData,
  input  logic [ADDR_W-1:0] RAddrA,
  input  logic [ADDR_W-1:0] RAddrB,
  output logic [WIDTH-1:0]  RDataA,
  output logic [WIDTH-1:0]  RDataB
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd_a_d;
  logic [WIDTH-1:0] rd_b_d;

  // Storage array. With ZERO_REG the cell at address 0 does not exist, so
  // writes there are discarded by construction.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (ZERO_REG != 0 && g == 0) begin : g_zero
      assign regs[g] = '0;
    end else begin : g_cell
      dff_reg #(.WIDTH(WIDTH)) u_cell (
        .CLK   (CLK),
        .RST_N (RST_N),
        .En    (WE && (WAddr == ADDR_W'(g))),
        .D     (WData),
        .Q     (regs[g])
      );
    end
  end

  // Read muxes with write-first bypass. The bypass is suppressed at the
  // zero register so that address 0 keeps reading 0 even while written.
  always_comb begin
    rd_a_d = regs[RAddrA];
    rd_b_d = regs[RAddrB];
    if (WE && (WAddr == RAddrA) && !(ZERO_REG != 0 && RAddrA == '0)) begin
      rd_a_d = WData;
    end
    if (WE && (WAddr == RAddrB) && !(ZERO_REG != 0 && RAddrB == '0)) begin
      rd_b_d = WData;
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_rd_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .En    (1'b1),
    .D     (rd_a_d),
    .Q     (RDataA)
  );

  dff_reg #(.WIDTH(WIDTH)) u_rd_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .En    (1'b1),
    .D     (rd_b_d),
    .Q     (RDataB)
  );

endmodule : reg_file
